// File: rtl/mult_pkg.sv
// Shared types and helpers for the arbitrated multiplier: tag format,
// grant result and the round-robin search.
package mult_pkg;

  // Widest configuration supported; narrower instances zero-extend into these.
  localparam int MAX_NREQ = 16;
  localparam int MAX_ID_W = 4;
  localparam int POS_W    = MAX_ID_W + 1;

  // Requester id width, kept at least one bit wide.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Travels through the multiplier alongside the data.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } mult_tag_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } grant_t;

  // First set bit of valid searching ptr, ptr+1, ... modulo nreq.
  function automatic grant_t rr_next(input logic [MAX_NREQ-1:0] valid,
                                     input logic [MAX_ID_W-1:0] ptr,
                                     input int                  nreq);
    grant_t           g;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] lim;
    g   = '0;
    lim = POS_W'(nreq);
    // Walk from the farthest candidate back towards ptr so the nearest one wins.
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (i < nreq) begin
        pos = {1'b0, ptr} + POS_W'(i);
        if (pos >= lim) pos = pos - lim;
        if (valid[pos[MAX_ID_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = pos[MAX_ID_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Fixed-latency signed multiplier: operand register, combinational product,
// then LAT-1 product registers with a matching valid/tag shift register.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  mult_tag_t               in_tag_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output mult_tag_t               out_tag_o,
  output logic [2*DATA_WIDTH-1:0] c_o
);

  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [2*DATA_WIDTH-1:0] a_x, b_x, prod;
  mult_tag_t               tag_q [LAT];

  // Capture operands on issue.
  // NOTE: datapath registers carry no reset; only the valid/tag chain decides
  // whether their contents are ever looked at, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (in_tag_i.valid) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  // Sign-extend to full width; the low 2*DATA_WIDTH bits of that product are
  // exactly the signed two's-complement result.
  assign a_x  = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q};
  assign b_x  = {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q};
  assign prod = a_x * b_x;

  // Valid/tag shift register, cleared on reset so flushed ops never emerge.
  // NOTE: sequential state is written with <= so every stage samples the
  // previous stage's old value on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= in_tag_i;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_tag_o = tag_q[LAT-1];

  if (LAT == 1) begin : g_no_stages
    assign c_o = prod;
  end else begin : g_stages
    logic [2*DATA_WIDTH-1:0] data_q [LAT-1];

    // Product delay line matching the tag chain.
    always_ff @(posedge clk) begin
      data_q[0] <= prod;
      for (int i = 1; i < LAT - 1; i++) data_q[i] <= data_q[i-1];
    end

    assign c_o = data_q[LAT-2];
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier between NREQ
// requesters; products return in issue order on a broadcast port.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NREQ       = 4,
  parameter  int LAT        = 2,
  localparam int ID_W       = id_width(NREQ),
  localparam int CNT_W      = $clog2(LAT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_hold,
  input  logic [NREQ-1:0]              i_req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0]   i_req_a,
  input  logic [NREQ*DATA_WIDTH-1:0]   i_req_b,
  output logic [NREQ-1:0]              o_req_ready,
  output logic                         o_rsp_valid,
  output logic [ID_W-1:0]              o_rsp_id,
  output logic [2*DATA_WIDTH-1:0]      o_rsp_c,
  output logic [CNT_W-1:0]             o_inflight,
  output logic                         o_busy
);

  logic [MAX_NREQ-1:0]     valid_ext;
  grant_t                  grant;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   issue_a, issue_b;
  mult_tag_t               issue_tag, pipe_tag;
  logic [2*DATA_WIDTH-1:0] pipe_c;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    rsp_valid_q;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [2*DATA_WIDTH-1:0] rsp_c_q;

  // Grant the first valid requester at or after ptr; gated by reset and hold.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = i_req_valid;
    grant                  = rr_next(valid_ext, MAX_ID_W'(ptr_q), NREQ);
    o_req_ready            = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_req_ready[k] = !rst && !i_hold && grant.found && (grant.idx == MAX_ID_W'(k));
    end
  end

  // Select the granted operands and advance the pointer past the winner.
  always_comb begin
    issue   = |(i_req_valid & o_req_ready);
    issue_a = '0;
    issue_b = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (o_req_ready[k]) begin
        issue_a = i_req_a[k*DATA_WIDTH +: DATA_WIDTH];
        issue_b = i_req_b[k*DATA_WIDTH +: DATA_WIDTH];
        ptr_d   = (k == NREQ - 1) ? '0 : ID_W'(k + 1);
      end
    end
    issue_tag = '{valid: issue, id: grant.idx};
  end

  mult_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT        (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_tag_i  (issue_tag),
    .a_i       (issue_a),
    .b_i       (issue_b),
    .out_tag_o (pipe_tag),
    .c_o       (pipe_c)
  );

  // Narrow the returning tag id and track ops between issue and response.
  always_comb begin
    rsp_id_d = rsp_id_q;
    for (int k = 0; k < NREQ; k++) begin
      if (pipe_tag.id == MAX_ID_W'(k)) rsp_id_d = ID_W'(k);
    end
    inflight_d = inflight_q;
    case ({issue, pipe_tag.valid})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Pointer, in-flight count and response registers; id/product hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      inflight_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= pipe_tag.valid;
      if (pipe_tag.valid) begin
        rsp_id_q <= rsp_id_d;
        rsp_c_q  <= pipe_c;
      end
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_c     = rsp_c_q;
  assign o_inflight  = inflight_q;
  assign o_busy      = (inflight_q != '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a random soak,
// all compared against a queue-based reference model of the arbiter.
module tb_mult_arbiter;

  localparam int W     = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int ID_W  = 2;
  localparam int CNT_W = 2;
  localparam int OBS_W = NREQ + 1 + ID_W + 2*W + CNT_W + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 hold = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*W-1:0]    req_a = '0;
  logic [NREQ*W-1:0]    req_b = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [2*W-1:0]       rsp_c;
  logic [CNT_W-1:0]     inflight;
  logic                 busy;

  mult_arbiter #(.DATA_WIDTH(W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (hold),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_c     (rsp_c),
    .o_inflight  (inflight),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: an op queue stamped with the edge it issued on.
  typedef struct {
    int          issue;
    int          id;
    logic [63:0] c;
  } op_t;

  op_t         q[$];
  int          cyc = 0;
  int          m_ptr = 0;
  int          last_id = 0;
  logic [63:0] last_c = '0;
  int          n_issued = 0;
  int          checks = 0;
  int          errors = 0;
  logic [OBS_W-1:0] exp_v;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = $signed(a);
    y = $signed(b);
    return 64'(x * y);
  endfunction

  function automatic int model_grant();
    if (rst || hold) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [OBS_W-1:0] expected();
    logic [NREQ-1:0] rdy;
    logic            v;
    int              id, infl, g;
    logic [63:0]     c;
    rdy = '0; v = 1'b0; id = last_id; c = last_c; infl = 0;
    g = model_grant();
    if (g >= 0) rdy[g] = 1'b1;
    if (q.size() > 0 && q[0].issue + LAT == cyc) begin
      v = 1'b1; id = q[0].id; c = q[0].c;
    end
    foreach (q[i]) if (q[i].issue + LAT > cyc) infl++;
    return {rdy, v, ID_W'(id), c, CNT_W'(infl), infl != 0};
  endfunction

  function automatic logic [OBS_W-1:0] observed();
    return {req_ready, rsp_valid, rsp_id, rsp_c, inflight, busy};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Advance the model across one clock edge and return just after it.
  task automatic tick();
    int g;
    if (q.size() > 0 && q[0].issue + LAT == cyc) begin
      last_id = q[0].id;
      last_c  = q[0].c;
      void'(q.pop_front());
    end
    g = model_grant();
    if (g >= 0) begin
      q.push_back('{issue: cyc + 1, id: g,
                    c: ref_prod(req_a[g*W +: W], req_b[g*W +: W])});
      m_ptr = (g + 1) % NREQ;
      n_issued++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.delete(); m_ptr = 0; last_id = 0; last_c = '0;
    req_valid = '1; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL reset cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    bit seen = 0;
    req_a[0 +: W] = 32'd3;
    req_b[0 +: W] = 32'hFFFF_FFFB;
    req_valid = 4'b0001;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL single cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      if (rsp_valid) begin
        seen = 1; checks++;
        if (rsp_c !== 64'hFFFF_FFFF_FFFF_FFF1 || rsp_id !== 2'd0) begin
          errors++; $display("FAIL single_value: got id %0d c %h expected id 0 c fffffffffffffff1", rsp_id, rsp_c);
        end
      end
      tick();
      req_valid = '0;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL single_response: got no pulse expected one");
    end
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < 8 + LAT + 2; i++) begin
      req_valid = (i < 8) ? '1 : '0;
      for (int k = 0; k < NREQ; k++) begin
        req_a[k*W +: W] = $urandom;
        req_b[k*W +: W] = $urandom;
      end
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL round_robin cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      if (i < 8) begin
        checks++;
        if (req_ready !== NREQ'(1 << (i % NREQ))) begin
          errors++; $display("FAIL rr_order step %0d: got %b expected %b", i, req_ready, NREQ'(1 << (i % NREQ)));
        end
      end
      tick();
    end
  endtask

  task automatic test_extremes();
    req_a[2*W +: W] = 32'h8000_0000; req_b[2*W +: W] = 32'h8000_0000;
    req_a[3*W +: W] = 32'h7FFF_FFFF; req_b[3*W +: W] = 32'hFFFF_FFFF;
    req_a[1*W +: W] = 32'h0;         req_b[1*W +: W] = $urandom;
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      case (i)
        0:       req_valid = 4'b0100;
        1:       req_valid = 4'b1000;
        2:       req_valid = 4'b0010;
        default: req_valid = 4'b0000;
      endcase
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL extremes cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      if (rsp_valid) begin
        logic [63:0] want;
        want = (rsp_id == 2) ? 64'h4000_0000_0000_0000 :
               (rsp_id == 3) ? 64'hFFFF_FFFF_8000_0001 : 64'h0;
        checks++;
        if (rsp_c !== want) begin
          errors++; $display("FAIL extreme_value id %0d: got %h expected %h", rsp_id, rsp_c, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    int want_infl [4] = '{2, 1, 0, 0};
    req_valid = 4'b0010;
    req_a[1*W +: W] = $urandom; req_b[1*W +: W] = $urandom;
    for (int i = 0; i < 2 + 4; i++) begin
      hold = (i >= 2);
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL hold cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      if (i >= 2) begin
        checks++;
        if (inflight !== CNT_W'(want_infl[i-2]) || req_ready !== '0 || busy !== (want_infl[i-2] != 0)) begin
          errors++; $display("FAIL hold_drain step %0d: got infl %0d ready %b busy %b expected infl %0d ready 0",
                             i - 2, inflight, req_ready, busy, want_infl[i-2]);
        end
      end
      tick();
      req_b[1*W +: W] = $urandom;
    end
    hold = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    req_valid = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL midflight_issue cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      tick();
    end
    checks++;
    if (inflight !== CNT_W'(2)) begin
      errors++; $display("FAIL midflight_pre: got inflight %0d expected 2", inflight);
    end
    rst = 1'b1;
    q.delete(); m_ptr = 0; last_id = 0; last_c = '0;
    for (int i = 0; i < 2 + LAT + 3; i++) begin
      if (i == 2) begin rst = 1'b0; req_valid = '0; end
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL midflight cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      if (rsp_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midflight_flush: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_random_soak();
    int start = n_issued;
    int budget = 0;
    int waits [NREQ] = '{default: 0};
    while (n_issued - start < 10000 && budget < 30000) begin
      req_valid = NREQ'($urandom);
      hold = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NREQ; k++) begin
        req_a[k*W +: W] = pick_operand();
        req_b[k*W +: W] = pick_operand();
      end
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL soak cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k]) waits[k] = 0;
        else if (req_ready[k]) begin
          checks++;
          if (waits[k] > NREQ - 1) begin
            errors++; $display("FAIL fairness req %0d: got %0d waits expected <= %0d", k, waits[k], NREQ - 1);
          end
          waits[k] = 0;
        end else if (|req_ready) waits[k]++;
      end
      tick();
      budget++;
    end
    checks++;
    if (n_issued - start < 10000) begin
      errors++; $display("FAIL soak_budget: got %0d ops expected 10000", n_issued - start);
    end
    req_valid = '0;
    hold = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      exp_v = expected(); checks++;
      if (observed() !== exp_v) begin
        errors++; $display("FAIL soak_drain cycle %0d: got %h expected %h", cyc, observed(), exp_v);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_hold();
    test_reset_midflight();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
